button_bank: RTL and testbench
==============================

// Module: button_bank
// PURPOSE
//  CHANNELS-wide debouncer for front-panel/gamepad buttons; the generalised
//  successor of the single-channel press debouncer. Per channel: 2-flop
//  synchroniser, debounce of both press and release, one-cycle press/release
//  pulses. Sits between the board pins and the input/keyboard registers.
// PARAMETERS
//  CHANNELS       8      number of independent buttons
//  COUNTER_SIZE   8      width of each per-channel debounce counter
//  COUNTER_VALUE  255    counter value at which a level change is accepted (< 2**COUNTER_SIZE)
//  ACTIVE_LOW     0      CHANNELS-bit mask; bit=1 inverts that pin before the synchroniser
//  REPEAT_SIZE    16     width of per-channel repeat counter (BUTTON_REPEAT_EN only)
//  REPEAT_DELAY   1000   cycles from press pulse to first repeat pulse (>=2)
//  REPEAT_PERIOD  100    cycles between subsequent repeat pulses (>=2)
// PORTS
//  clk             in   1         system clock, all flops on posedge
//  reset           in   1         asynchronous, active-high
//  button_in       in   CHANNELS  raw pins, asynchronous to clk
//  button_state    out  CHANNELS  debounced level, 1 = pressed
//  button_pressed  out  CHANNELS  1-cycle pulse on accepted 0->1
//  button_released out  CHANNELS  1-cycle pulse on accepted 1->0
//  button_repeat   out  CHANNELS  1-cycle typematic pulse while held
//  any_pressed     out  1         OR of button_pressed, same cycle
// BEHAVIOUR
//  - Reset (async, any time): synchronisers, counters, state and all
//    outputs -> 0 (internal post-inversion "released"). Counting restarts
//    from 0 after deassertion; no pulses are emitted because of reset.
//  - Per channel: raw = button_in[i] ^ ACTIVE_LOW[i]; s1<=raw; s2<=s1.
//  - If s2 == button_state[i]: counter <= 0.
//    Else if counter == COUNTER_VALUE: button_state[i] <= s2, counter <= 0,
//    pressed/released pulse registered in the same edge.
//    Else counter <= counter+1 (never wraps; cleared before reaching 2**N).
//  - Latency: input stable from just before edge 1 -> state and pulse change
//    at edge COUNTER_VALUE+3; pulse high exactly one cycle.
//  - Any bounce (s2 returns to state) before acceptance clears the counter;
//    the full count restarts on the next mismatch.
//  - Channels fully independent; simultaneous acceptances on several channels
//    give simultaneous pulses; any_pressed is the OR of them.
//  - button_pressed and button_released never both high for one channel.
// CONFIGURATION
//  BUTTON_REPEAT_EN defined: per-channel repeat counter, cleared on the
//    press pulse and whenever button_state[i]==0. While held, button_repeat[i]
//    pulses REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD
//    cycles until release is accepted. No repeat pulse in the release-pulse
//    cycle. Repeat pulses do not affect button_pressed/any_pressed.
//  Not defined: button_repeat tied to 0; no repeat counters are synthesised.
// TESTING  (COUNTER_VALUE=3, CHANNELS=4, ACTIVE_LOW=4'b0010)
//  1 reset high mid-count with pin[0]=1 -> all outputs 0 immediately; after
//    release, state[0] rises 6 edges later, one pressed[0] pulse.
//  2 pin[0] 0->1 before edge 1, held -> state[0]=1 and pressed[0]=1 at edge 6,
//    pressed[0]=0 at edge 7; released path symmetric on 1->0.
//  3 pin[0] bounces 1,1,0,1,1,1,1 per cycle -> acceptance delayed until four
//    consecutive mismatched s2 samples; exactly one pressed pulse.
//  4 pin[1]=1 (idle, active-low) from reset -> state[1] stays 0; pin[1] 1->0
//    -> pressed[1] at edge 6.
//  5 pins[2]/[3] rise same cycle -> pressed[2], pressed[3], any_pressed high
//    in the same single cycle.
//  6 BUTTON_REPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=4, hold pin[0] -> repeat[0]
//    at press+10, +14, +18, ...; none after release accepted; none without macro.

Source files
------------

// File: rtl/button_bank.sv
// CHANNELS-wide button debouncer: 2-flop synchroniser, symmetric press/release debounce,
// one-cycle edge pulses. Define BUTTON_REPEAT_EN to add per-channel typematic repeat pulses.
module button_bank #(
   parameter int                  CHANNELS      = 8,
   parameter int                  COUNTER_SIZE  = 8,
   parameter int                  COUNTER_VALUE = 255,
   parameter logic [CHANNELS-1:0] ACTIVE_LOW    = '0
`ifdef BUTTON_REPEAT_EN
   ,
   parameter int                  REPEAT_SIZE   = 16,
   parameter int                  REPEAT_DELAY  = 1000,
   parameter int                  REPEAT_PERIOD = 100
`endif
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] button_in,
   output logic [CHANNELS-1:0] button_state,
   output logic [CHANNELS-1:0] button_pressed,
   output logic [CHANNELS-1:0] button_released,
   output logic [CHANNELS-1:0] button_repeat,
   output logic                any_pressed
);

   localparam logic [COUNTER_SIZE-1:0] CNT_LIMIT = COUNTER_SIZE'(COUNTER_VALUE);

   logic [CHANNELS-1:0]     sync_p0;
   logic [CHANNELS-1:0]     sync_p1;
   logic [COUNTER_SIZE-1:0] cnt [CHANNELS];
   logic [CHANNELS-1:0]     accept;

   // A level change is accepted on the edge where the counter already sits at its limit.
   always_comb begin
      accept = '0;
      for (int i = 0; i < CHANNELS; i++)
         accept[i] = (sync_p1[i] != button_state[i]) && (cnt[i] == CNT_LIMIT);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_p0         <= '0;
         sync_p1         <= '0;
         button_state    <= '0;
         button_pressed  <= '0;
         button_released <= '0;
         for (int i = 0; i < CHANNELS; i++)
            cnt[i] <= '0;
      end else begin
         // stage p0/p1: synchroniser on the polarity-corrected pins
         sync_p0         <= button_in ^ ACTIVE_LOW;
         sync_p1         <= sync_p0;
         button_pressed  <= accept & sync_p1;
         button_released <= accept & ~sync_p1;
         for (int i = 0; i < CHANNELS; i++) begin
            if (sync_p1[i] == button_state[i]) begin
               cnt[i] <= '0;
            end else if (accept[i]) begin
               button_state[i] <= sync_p1[i];
               cnt[i]          <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   assign any_pressed = |button_pressed;

`ifdef BUTTON_REPEAT_EN
   localparam logic [REPEAT_SIZE-1:0] DELAY_LAST  = REPEAT_SIZE'(REPEAT_DELAY - 1);
   localparam logic [REPEAT_SIZE-1:0] PERIOD_LAST = REPEAT_SIZE'(REPEAT_PERIOD - 1);

   logic [REPEAT_SIZE-1:0] rep_cnt [CHANNELS];
   logic [CHANNELS-1:0]    rep_periodic;

   // Any acceptance (press or release) restarts the schedule; released channels stay idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         button_repeat <= '0;
         rep_periodic  <= '0;
         for (int i = 0; i < CHANNELS; i++)
            rep_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            button_repeat[i] <= 1'b0;
            if (!button_state[i] || accept[i]) begin
               rep_cnt[i]      <= '0;
               rep_periodic[i] <= 1'b0;
            end else if (rep_cnt[i] == (rep_periodic[i] ? PERIOD_LAST : DELAY_LAST)) begin
               button_repeat[i] <= 1'b1;
               rep_cnt[i]       <= '0;
               rep_periodic[i]  <= 1'b1;
            end else begin
               rep_cnt[i] <= rep_cnt[i] + 1'b1;
            end
         end
      end
   end
`else
   assign button_repeat = '0;
`endif

endmodule

// File: tb/tb_button_bank.sv
// Bench for button_bank: window-based reference model checked every cycle, directed
// literal scenarios, then randomized pin activity with occasional asynchronous resets.
module tb_button_bank;

   localparam int            CH   = 4;
   localparam int            CV   = 3;
   localparam int            W    = CV + 1;
   localparam logic [CH-1:0] AL   = 4'b0010;
   localparam int            RDLY = 10;
   localparam int            RPER = 4;
`ifdef BUTTON_REPEAT_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [CH-1:0] button_in = AL;
   logic [CH-1:0] button_state, button_pressed, button_released, button_repeat;
   logic          any_pressed;

   int tests = 0;
   int fails = 0;

   button_bank #(
      .CHANNELS(CH),
      .COUNTER_SIZE(4),
      .COUNTER_VALUE(CV),
      .ACTIVE_LOW(AL)
`ifdef BUTTON_REPEAT_EN
      ,
      .REPEAT_SIZE(8),
      .REPEAT_DELAY(RDLY),
      .REPEAT_PERIOD(RPER)
`endif
   ) dut (
      .clk(clk),
      .reset(reset),
      .button_in(button_in),
      .button_state(button_state),
      .button_pressed(button_pressed),
      .button_released(button_released),
      .button_repeat(button_repeat),
      .any_pressed(any_pressed)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a level is accepted once the last W synchronised samples all
   // disagree with the current state; repeats are counted as edges since the press.
   logic [CH-1:0] m_p0, m_p1, m_s2;
   logic [CH-1:0] m_state, m_pr, m_rl, m_rep;
   bit            m_win [CH][W];
   int            m_since [CH];
   bit            m_acc;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_p0 = '0; m_p1 = '0; m_state = '0; m_pr = '0; m_rl = '0; m_rep = '0;
         for (int c = 0; c < CH; c++) begin
            m_since[c] = 0;
            for (int k = 0; k < W; k++) m_win[c][k] = 1'b0;
         end
      end else begin
         m_s2 = m_p1;
         m_p1 = m_p0;
         m_p0 = button_in ^ AL;
         m_pr = '0; m_rl = '0; m_rep = '0;
         for (int c = 0; c < CH; c++) begin
            for (int k = W - 1; k > 0; k--) m_win[c][k] = m_win[c][k-1];
            m_win[c][0] = m_s2[c];
            m_acc = 1'b1;
            for (int k = 0; k < W; k++)
               if (m_win[c][k] == m_state[c]) m_acc = 1'b0;
            if (m_state[c] && !m_acc) begin
               m_since[c]++;
               if (REP_EN && m_since[c] >= RDLY && ((m_since[c] - RDLY) % RPER) == 0)
                  m_rep[c] = 1'b1;
            end
            if (m_acc) begin
               m_state[c] = m_s2[c];
               m_pr[c]    = m_s2[c];
               m_rl[c]    = !m_s2[c];
               m_since[c] = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         check("model_state", button_state, m_state);
         check("model_pressed", button_pressed, m_pr);
         check("model_released", button_released, m_rl);
         check("model_repeat", button_repeat, m_rep);
         check("model_any", any_pressed, |m_pr);
         check("press_release_excl", button_pressed & button_released, 0);
      end
   end

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int pat [7] = '{1, 1, 0, 1, 1, 1, 1};
   int npress;
   int rate;

   initial begin
      repeat (3) @(negedge clk);
      #1 reset = 1'b0;

      // idle with the active-low pin high: nothing pressed
      edges(10);
      check("idle_state", button_state, 0);

      // clean press, hold (repeats if enabled), clean release
      button_in[0] = 1'b1;
      for (int e = 1; e <= 26; e++) begin
         edges(1);
         check("press_state0", button_state[0], e >= 6);
         check("press_pulse0", button_pressed[0], e == 6);
         check("press_any", any_pressed, e == 6);
         check("hold_repeat0", button_repeat[0],
               REP_EN && e >= 6 + RDLY && ((e - 6 - RDLY) % RPER) == 0);
      end
      button_in[0] = 1'b0;
      for (int e = 1; e <= 20; e++) begin
         edges(1);
         check("rel_state0", button_state[0], e < 6);
         check("rel_pulse0", button_released[0], e == 6);
         check("rel_repeat0", button_repeat[0], REP_EN && e == 2);
      end

      // bounce restarts the count
      npress = 0;
      for (int e = 1; e <= 15; e++) begin
         if (e <= 7) button_in[0] = pat[e-1][0];
         edges(1);
         if (button_pressed[0]) npress++;
         check("bounce_pulse0", button_pressed[0], e == 9);
      end
      check("bounce_count", npress, 1);
      button_in[0] = 1'b0;
      edges(30);

      // active-low channel
      button_in[1] = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         edges(1);
         check("al_pulse1", button_pressed[1], e == 6);
      end
      button_in[1] = 1'b1;
      edges(12);

      // simultaneous presses on two channels
      button_in[3:2] = 2'b11;
      for (int e = 1; e <= 8; e++) begin
         edges(1);
         check("sim_pulse32", button_pressed[3:2], (e == 6) ? 2'b11 : 2'b00);
         check("sim_any", any_pressed, e == 6);
      end

      // asynchronous reset mid-count with channels 2/3 held
      button_in[0] = 1'b1;
      edges(3);
      check("pre_reset_state", button_state, 4'b1100);
      #2 reset = 1'b1;
      #1;
      check("rst_state", button_state, 0);
      check("rst_pressed", button_pressed, 0);
      check("rst_released", button_released, 0);
      check("rst_repeat", button_repeat, 0);
      check("rst_any", any_pressed, 0);
      @(negedge clk);
      #1 reset = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         edges(1);
         check("post_rst_state0", button_state[0], e >= 6);
         check("post_rst_pulse", button_pressed, (e == 6) ? 4'b1101 : 4'b0000);
      end
      button_in = AL;
      edges(12);

      // randomized activity with varying bounce rates and occasional async resets
      rate = 8;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         #1;
         if (cyc % 40 == 0) begin
            case ($urandom_range(2))
               0:       rate = 2;
               1:       rate = 8;
               default: rate = 60;
            endcase
         end
         for (int c = 0; c < CH; c++)
            if ($urandom_range(rate - 1) == 0) button_in[c] = ~button_in[c];
         if ($urandom_range(599) == 0) begin
            #2 reset = 1'b1;
            @(negedge clk);
            #1 reset = 1'b0;
         end
      end
      edges(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
